instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage for the 16-bit accumulator computer. It sits between the byte-wide MainMemory and the Control sequencer. It reads two consecutive bytes per instruction through the shared memory port and assembles them big-endian into a 16-bit word. The word and its address go into a 2-entry instruction buffer that Control drains with a valid/ready handshake; Control redirects fetch on jumps.

## Interface
- `RESET_PC`, default 16'h0000: fetch address loaded on reset (bit 0 ignored).
- `MEM_BYTES`, default 16384: memory size in bytes, power of two; all fetch addresses are taken modulo this.
- `clock` in 1: single clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high; sampled on posedge; priority over every other input.
- `mem_addr` out 16: byte address to MainMemory (combinational from state/pc).
- `mem_rd_en` out 1: fetch is using the memory port this cycle (port mux select; memory write_enable held low by the top level).
- `mem_grant` in 1: port available to fetch; low while Control performs a data load/store.
- `mem_rdata` in 8: MainMemory data_out; holds the byte addressed in the previous cycle.
- `instr` out 16: buffer head instruction, {byte[pc], byte[pc+1]}.
- `instr_pc` out 16: byte address of buffer head.
- `instr_valid` out 1: buffer non-empty.
- `instr_ready` in 1: Control accepts head; pop on valid & ready at posedge.
- `jump` in 1: one-cycle redirect request.
- `jump_addr` in 16: new fetch address; bit 0 forced to 0.

## Operation
- Registers: pc (word-aligned), hi_byte, state, 2-entry buffer {instr, pc} with count 0..2.
- FETCH_HI: mem_addr = pc. Issue (mem_rd_en=1) only if mem_grant & count<2. Otherwise wait in FETCH_HI with mem_rd_en=0. Issue -> FETCH_LO.
- FETCH_LO: mem_addr = (pc+1) mod MEM_BYTES, mem_rd_en = mem_grant. If grant: hi_byte <= mem_rdata, -> WRITE. If no grant: discard and restart -> FETCH_HI with pc unchanged.
- WRITE: mem_rd_en=0, mem_addr = pc, grant ignored. Push {hi_byte, mem_rdata} with pc. Then pc <= (pc+2) mod MEM_BYTES, -> FETCH_HI.
- Buffer: FIFO order. Push and pop in the same posedge are both honoured, count unchanged. Push never occurs when count==2, because issue is gated on count<2 and only pops can happen in flight.
- jump (reset low): pc <= jump_addr & ~1 mod MEM_BYTES, count <= 0, state <= FETCH_HI. Any in-flight bytes and any same-cycle push or pop are discarded.
- Reset: pc=RESET_PC, state=FETCH_HI, count=0, hi_byte=0, buffer contents 0. mem_rd_en forced 0 while reset is high. Reset beats a simultaneous jump.
- Output reset values: mem_rd_en 0, mem_addr RESET_PC, instr_valid 0, instr 16'h0000, instr_pc 16'h0000.
- instr and instr_pc are stale when instr_valid=0; the bench must not check them then.

## Timing
- Cycle 0 is the FETCH_HI issue cycle. MainMemory latches byte[pc] at the end of cycle 0.
- Cycle 1, FETCH_LO: mem_rdata = byte[pc]; the end-of-cycle edge captures hi_byte and memory latches byte[pc+1].
- Cycle 2, WRITE: mem_rdata = byte[pc+1]; the edge pushes the word.
- Cycle 3: instr_valid=1. Latency from issue to valid is 3 cycles.
- Next FETCH_HI issue is also cycle 3. Sustained throughput is 1 instruction per 3 cycles with grant=1 and ready=1.
- First issue occurs in the first cycle after reset deasserts. First instr_valid comes 3 cycles later.
- Wrap: pc = MEM_BYTES-2 fetches bytes MEM_BYTES-2 and MEM_BYTES-1, then pc=0. mem_addr bits above log2(MEM_BYTES) are always 0.
- After jump asserted at edge N: instr_valid=0 in cycle N+1 and issue from the new pc in cycle N+1 (if grant). The new instruction is valid at N+4.
- A grant drop in FETCH_HI stalls only; a drop in FETCH_LO costs a full restart (same pc, no partial word ever pushed).

## Test plan
- Reset, mem[0..3]=12,34,AB,CD, grant=ready=1 -> instr=16'h1234, instr_pc=0 valid 3 cycles after first issue. Then 16'hABCD, instr_pc=2, exactly 3 cycles later; mem_rd_en=0 during reset.
- ready=0 -> buffer fills with 1234 and ABCD; mem_rd_en stays 0 in FETCH_HI; pc=4. One ready pulse pops 1234, head becomes ABCD, and fetch of pc=4 issues the next cycle.
- grant dropped during FETCH_LO of pc=0 -> FETCH_HI restart at pc=0. Result is still 16'h1234 at instr_pc 0, no garbled or duplicate entries, valid delayed by 2 cycles.
- Buffer holding 2 entries, jump with jump_addr=16'h0101 -> instr_valid=0 next cycle. Next instr = {mem[0x100], mem[0x101]}, instr_pc=16'h0100, valid 3 cycles after the jump.
- jump_addr=16'h3FFE, mem[3FFE]=55, mem[3FFF]=66, mem[0]=12, mem[1]=34 -> 16'h5566 @3FFE, then 16'h1234 @0000. mem_addr never exceeds 16'h3FFF.
- reset and jump in the same cycle mid-fetch -> reset wins: pc=RESET_PC, buffer empty. Push and pop in the same edge at count=1 -> count stays 1, order preserved.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: the shared MainMemory read port and the instruction
// stream towards Control (including the jump redirect).
//
// Instruction stream handshake: instr/instr_pc are meaningful only while
// instr_valid is high. A word is consumed at a rising clock edge where
// instr_valid & instr_ready are both high. instr_valid never depends
// combinationally on instr_ready. A jump in the same cycle cancels that
// consumption.
interface instr_fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_grant;
  logic [7:0]  mem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic [15:0] jump_addr;

  // Fetch unit side.
  modport master (
    output mem_addr, mem_rd_en, instr, instr_pc, instr_valid,
    input  mem_grant, mem_rdata, instr_ready, jump, jump_addr
  );

  // Memory / Control side.
  modport slave (
    input  mem_addr, mem_rd_en, instr, instr_pc, instr_valid,
    output mem_grant, mem_rdata, instr_ready, jump, jump_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads two bytes per instruction through the shared
// memory port, assembles them big-endian and queues {instr, pc} in a 2-entry
// buffer drained by Control. Entry 0 of the buffer is always the head.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_BYTES = 16384
) (
  input  logic              clock,
  input  logic              reset,
  instr_fetch_unit_if.master bus,
  output logic [1:0]        state_dbg
);

  localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);
  localparam logic [15:0] PC_INIT   = RESET_PC & ADDR_MASK & 16'hFFFE;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       pc_q, pc_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic [1:0]        count_q, count_d;
  logic [1:0][15:0]  buf_instr_q, buf_instr_d;
  logic [1:0][15:0]  buf_pc_q, buf_pc_d;

  logic              issue;
  logic              push;
  logic              pop;
  logic [1:0]        count_after_pop;

  // Memory port drive: the high byte is requested in FETCH_HI, the low byte in FETCH_LO.
  always_comb begin
    issue         = (state_q == FETCH_HI) && bus.mem_grant && (count_q != 2'd2);
    bus.mem_addr  = (state_q == FETCH_LO) ? ((pc_q + 16'd1) & ADDR_MASK) : pc_q;
    bus.mem_rd_en = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH_HI: bus.mem_rd_en = issue;
        FETCH_LO: bus.mem_rd_en = bus.mem_grant;
        default:  bus.mem_rd_en = 1'b0;
      endcase
    end
  end

  assign bus.instr       = buf_instr_q[0];
  assign bus.instr_pc    = buf_pc_q[0];
  assign bus.instr_valid = (count_q != 2'd0);
  assign state_dbg       = state_q;

  // Next-state: fetch sequencing, buffer push/pop, and jump redirect on top.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    hi_byte_d       = hi_byte_q;
    count_d         = count_q;
    buf_instr_d     = buf_instr_q;
    buf_pc_d        = buf_pc_q;
    push            = 1'b0;
    pop             = (count_q != 2'd0) && bus.instr_ready;
    count_after_pop = count_q;

    case (state_q)
      FETCH_HI: begin
        if (issue) state_d = FETCH_LO;
      end
      FETCH_LO: begin
        // Losing the port here means the high byte in flight is gone too,
        // so the whole word is refetched from pc.
        if (bus.mem_grant) begin
          hi_byte_d = bus.mem_rdata;
          state_d   = WRITE;
        end else begin
          state_d   = FETCH_HI;
        end
      end
      WRITE: begin
        push    = 1'b1;
        pc_d    = (pc_q + 16'd2) & ADDR_MASK;
        state_d = FETCH_HI;
      end
      default: state_d = FETCH_HI;
    endcase

    // Pop shifts entry 1 forward; push then lands behind whatever remains.
    if (pop) begin
      buf_instr_d[0]  = buf_instr_q[1];
      buf_pc_d[0]     = buf_pc_q[1];
      count_after_pop = count_q - 2'd1;
    end
    if (push) begin
      if (count_after_pop == 2'd0) begin
        buf_instr_d[0] = {hi_byte_q, bus.mem_rdata};
        buf_pc_d[0]    = pc_q;
      end else begin
        buf_instr_d[1] = {hi_byte_q, bus.mem_rdata};
        buf_pc_d[1]    = pc_q;
      end
    end
    count_d = count_after_pop + {1'b0, push};

    // Redirect flushes the buffer and drops any word in flight.
    if (bus.jump) begin
      pc_d        = bus.jump_addr & ADDR_MASK & 16'hFFFE;
      count_d     = 2'd0;
      state_d     = FETCH_HI;
      hi_byte_d   = hi_byte_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
    end
  end

  // State registers; reset beats everything including a jump.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH_HI;
      pc_q        <= PC_INIT;
      hi_byte_q   <= 8'h00;
      count_q     <= 2'd0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hi_byte_q   <= hi_byte_d;
      count_q     <= count_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule
